mult_pipe_unit: RTL and testbench
=================================

# mult_pipe_unit

Parametrised pipelined integer multiply unit for the CPU execute stage. It implements all four RV32M multiply operations (MUL, MULH, MULHSU, MULHU) with a configurable XLEN and pipeline depth. It carries valid and destination-register tags alongside the product and publishes an in-flight destination mask for hazard stalls. It supports pipeline hold and flush, and can optionally fuse a MULH-family/MUL pair on identical operands.

## Interface
- XLEN, 32, operand and result width
- STAGES, 3, accept-to-result latency in cycles; must be ≥1
- REG_W, 5, destination register address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; clock is single, reset polarity and synchronicity are fixed
- in_valid  in  1  operation offered this cycle
- in_ready  out  1  equals !hold
- op  in  2  00 MUL, 01 MULH (S×S), 10 MULHSU (S×U), 11 MULHU (U×U)
- a, b  in  XLEN  operands rs1, rs2
- rd_addr_i  in  REG_W  destination register
- hold  in  1  freeze every stage; no accept, no retire
- flush  in  1  discard all in-flight operations and any input offered this cycle
- out_valid  out  1  result retiring this cycle
- out_data  out  XLEN  result
- out_rd  out  REG_W  destination of retiring result
- pending_mask  out  2^REG_W  bit r is set while a valid in-flight op targets r; bit 0 is always 0
- fuse_hit  out  1  retiring result was produced by fusion; tied 0 when fusion is compiled out

## Operation
- Accept: in_valid & !hold & !flush. Stage 0 captures valid, op, rd, fused flag, and the full product.
- Arithmetic: a and b are each extended to XLEN+1 bits.
  - a is sign-extended for op 00/01/10.
  - b is sign-extended for op 00/01.
  - The signed (2XLEN+2)-bit product is truncated to 2XLEN bits.
  - MUL returns bits [XLEN-1:0]; all other ops return [2XLEN-1:XLEN].
- Stages 1..STAGES-1 shift {valid, op, rd, fused, product} each non-held cycle. The product path may be retimed by synthesis.
- Retire: stage STAGES-1 drives the registered outputs. out_valid is a one-cycle pulse per retired op.
- Retire registers update only on a valid retire. Otherwise out_data and out_rd hold their last value, and out_valid is 0.
- pending_mask is the OR over valid stages of a one-hot decode of rd, with bit 0 masked. It is combinational from stage registers.
- flush: every stage valid clears on the next edge. Input offered in the flush cycle is dropped. pending_mask is 0 the cycle after.
- flush with hold: flush wins.
- Ops with rd = 0 flow and retire normally (out_valid = 1). The writeback stage ignores them.

## Timing
- Accept in cycle N retires with out_valid = 1 in cycle N+STAGES, plus one extra cycle per held cycle in between.
- Throughput is one op per cycle. Ops retire strictly in accept order.
- hold held k cycles delays every in-flight op by exactly k cycles. out_valid stays 0 during hold and no state changes.
- Reset values: out_valid 0, out_data 0, out_rd 0, fuse_hit 0, pending_mask 0, all stage valids 0, fusion tag invalid.
- Reset asserted mid-operation kills all in-flight ops. Nothing retires after release until new accepts.

## Configuration
- MULT_PIPE_FUSE_EN defined:
  - A tag holds {a, b, valid} of the most recently accepted op. Flush and reset invalidate it.
  - An incoming MUL whose a, b equal the valid tag is accepted with fused = 1.
  - When the previous accepted op retires, the unit keeps its full product in a last-product register.
  - A fused MUL retires with out_data = last-product[XLEN-1:0] and fuse_hit = 1. The low half is signedness-independent.
  - Multiplier input registers are not loaded for a fused op. This is a power saving; latency and ordering are unchanged.
- MULT_PIPE_FUSE_EN undefined: no tag and no last-product register. fuse_hit is tied 0 and every op uses the multiplier.

## Test plan
All scenarios use XLEN=32, STAGES=3.
- MULH a=0x80000000, b=0x80000000, rd=3 → 3 cycles later out_valid=1, out_data=0x40000000, out_rd=3. MUL on the same operands → 0x00000000.
- a=b=0xFFFFFFFF issued back-to-back as MULHSU rd=1, MULHU rd=2, MUL rd=4 → consecutive retires 0xFFFFFFFF/1, 0xFFFFFFFE/2, 0x00000001/4. pending_mask=0x16 while all three are in flight.
- 4 back-to-back ops with hold asserted 2 cycles after the second accept → retires delayed exactly 2 cycles, order preserved, in_ready=0 during hold.
- 3 ops in flight, then flush → no out_valid afterwards, pending_mask=0 next cycle. An op offered during the flush cycle never retires.
- rst pulsed low with 2 ops in flight → all outputs 0 immediately, no retire after release. A new MUL 6×7 retires 42 three cycles after accept.
- Fusion (MULT_PIPE_FUSE_EN defined): MULHU 7×9 rd=5, then MUL 7×9 rd=6 → retires 0/5 with fuse_hit=0, then 63/6 with fuse_hit=1. Repeat with flush between the two ops → MUL retires 63 with fuse_hit=0.

Source files
------------

// File: rtl/mult_pipe_unit.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with hold, flush and an in-flight rd mask.
// Define MULT_PIPE_FUSE_EN to reuse the previous product for a MUL on identical operands.
module mult_pipe_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int REG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [XLEN-1:0]          a,
  input  logic [XLEN-1:0]          b,
  input  logic [REG_W-1:0]         rd_addr_i,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_data,
  output logic [REG_W-1:0]         out_rd,
  output logic [(1<<REG_W)-1:0]    pending_mask,
  output logic                     fuse_hit
);

  localparam int PW   = 2 * XLEN;
  localparam int NREG = 1 << REG_W;

  logic             accept_s;
  logic             fuse_s;
  logic             sa_s;
  logic             sb_s;
  logic [PW-1:0]    a_w_s;
  logic [PW-1:0]    b_w_s;
  logic [PW-1:0]    prod_s;

  logic             feed_vld_s;
  logic             feed_fus_s;
  logic [1:0]       feed_op_s;
  logic [REG_W-1:0] feed_rd_s;
  logic [PW-1:0]    feed_prod_s;
  logic [XLEN-1:0]  res_s;

  logic [NREG-1:0]  pipe_mask_s;
  logic [NREG-1:0]  out_mask_s;
  logic [NREG-1:0]  pend_s;

  logic             out_vld_q;
  logic             out_fus_q;
  logic [XLEN-1:0]  out_data_q;
  logic [REG_W-1:0] out_rd_q;

  assign accept_s = in_valid & ~hold & ~flush;
  assign in_ready = ~hold;

  // Extending to 2*XLEN before multiplying gives the same low 2*XLEN bits as the (XLEN+1)-bit signed product.
  always_comb begin
    sa_s   = (op != 2'b11);
    sb_s   = (op[1] == 1'b0);
    a_w_s  = {{XLEN{sa_s & a[XLEN-1]}}, a};
    b_w_s  = {{XLEN{sb_s & b[XLEN-1]}}, b};
    prod_s = a_w_s * b_w_s;
  end

`ifdef MULT_PIPE_FUSE_EN
  logic [XLEN-1:0] tag_a_q;
  logic [XLEN-1:0] tag_b_q;
  logic            tag_vld_q;
  logic [PW-1:0]   last_prod_q;

  assign fuse_s = tag_vld_q & (op == 2'b00) & (a == tag_a_q) & (b == tag_b_q);

  // Operand tag of the most recently accepted op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_a_q   <= '0;
      tag_b_q   <= '0;
      tag_vld_q <= 1'b0;
    end else if (flush) begin
      tag_vld_q <= 1'b0;
    end else if (accept_s) begin
      tag_a_q   <= a;
      tag_b_q   <= b;
      tag_vld_q <= 1'b1;
    end
  end

  // Full product of the last multiplier-computed op to retire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_prod_q <= '0;
    end else if (!flush && !hold && feed_vld_s && !feed_fus_s) begin
      last_prod_q <= feed_prod_s;
    end
  end

  // Result select; a fused MUL takes the low half of the previous product
  always_comb begin
    if (feed_fus_s) begin
      res_s = last_prod_q[XLEN-1:0];
    end else if (feed_op_s == 2'b00) begin
      res_s = feed_prod_s[XLEN-1:0];
    end else begin
      res_s = feed_prod_s[PW-1:XLEN];
    end
  end
`else
  assign fuse_s = 1'b0;

  // Result select: MUL low half, MULH family high half
  always_comb begin
    if (feed_op_s == 2'b00) begin
      res_s = feed_prod_s[XLEN-1:0];
    end else begin
      res_s = feed_prod_s[PW-1:XLEN];
    end
  end
`endif

  generate
    if (STAGES > 1) begin : g_pipe
      localparam int PD = STAGES - 1;

      logic [PD-1:0]    vld_q;
      logic [PD-1:0]    fus_q;
      logic [1:0]       op_q   [PD];
      logic [REG_W-1:0] rd_q   [PD];
      logic [PW-1:0]    prod_q [PD];

      // Stage valid bits: flush beats hold, hold freezes
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
        end else if (flush) begin
          vld_q <= '0;
        end else if (!hold) begin
          vld_q[0] <= accept_s;
          for (int i = 1; i < PD; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      // Stage payload; the product register is not loaded for a fused op
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          fus_q <= '0;
          for (int i = 0; i < PD; i++) begin
            op_q[i]   <= 2'b00;
            rd_q[i]   <= '0;
            prod_q[i] <= '0;
          end
        end else if (!hold) begin
          if (accept_s) begin
            op_q[0]  <= op;
            rd_q[0]  <= rd_addr_i;
            fus_q[0] <= fuse_s;
            if (!fuse_s) begin
              prod_q[0] <= prod_s;
            end
          end
          for (int i = 1; i < PD; i++) begin
            op_q[i]   <= op_q[i-1];
            rd_q[i]   <= rd_q[i-1];
            fus_q[i]  <= fus_q[i-1];
            prod_q[i] <= prod_q[i-1];
          end
        end
      end

      assign feed_vld_s  = vld_q[PD-1];
      assign feed_fus_s  = fus_q[PD-1];
      assign feed_op_s   = op_q[PD-1];
      assign feed_rd_s   = rd_q[PD-1];
      assign feed_prod_s = prod_q[PD-1];

      // One-hot rd decode of every valid internal stage
      always_comb begin
        pipe_mask_s = '0;
        for (int i = 0; i < PD; i++) begin
          pipe_mask_s[rd_q[i]] = pipe_mask_s[rd_q[i]] | vld_q[i];
        end
      end
    end else begin : g_direct
      assign feed_vld_s  = accept_s;
      assign feed_fus_s  = fuse_s;
      assign feed_op_s   = op;
      assign feed_rd_s   = rd_addr_i;
      assign feed_prod_s = prod_s;
      assign pipe_mask_s = '0;
    end
  endgenerate

  // Retire stage: payload updates only on a valid retire, otherwise holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q  <= 1'b0;
      out_fus_q  <= 1'b0;
      out_data_q <= '0;
      out_rd_q   <= '0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
    end else if (!hold) begin
      out_vld_q <= feed_vld_s;
      if (feed_vld_s) begin
        out_data_q <= res_s;
        out_rd_q   <= feed_rd_s;
        out_fus_q  <= feed_fus_s;
      end
    end
  end

  // The retiring op still counts as in flight; x0 never stalls anyone
  always_comb begin
    out_mask_s           = '0;
    out_mask_s[out_rd_q] = out_vld_q;
    pend_s               = pipe_mask_s | out_mask_s;
  end

  assign pending_mask = {pend_s[NREG-1:1], 1'b0};
  assign out_valid    = out_vld_q & ~hold;
  assign out_data     = out_data_q;
  assign out_rd       = out_rd_q;
  assign fuse_hit     = out_valid & out_fus_q;

endmodule

// File: tb/tb_mult_pipe_unit.sv
// Directed self-checking bench for mult_pipe_unit (XLEN=32, STAGES=3).
module tb_mult_pipe_unit;

  localparam int XLEN   = 32;
  localparam int STAGES = 3;
  localparam int REG_W  = 5;
`ifdef MULT_PIPE_FUSE_EN
  localparam logic FZ = 1'b1;
`else
  localparam logic FZ = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic [REG_W-1:0]  rd_addr_i;
  logic              hold;
  logic              flush;
  logic              out_valid;
  logic [XLEN-1:0]   out_data;
  logic [REG_W-1:0]  out_rd;
  logic [31:0]       pending_mask;
  logic              fuse_hit;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount;

  mult_pipe_unit #(.XLEN(XLEN), .STAGES(STAGES), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .rd_addr_i(rd_addr_i), .hold(hold), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .pending_mask(pending_mask), .fuse_hit(fuse_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic h, input logic f);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = y;
    rd_addr_i = r;
    hold      = h;
    flush     = f;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_ret(input string tag, input logic [31:0] d, input logic [4:0] r, input logic fz);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_data"}, {32'd0, out_data}, {32'd0, d});
    check_eq({tag, "_rd"}, {59'd0, out_rd}, {59'd0, r});
    check_eq({tag, "_fuse"}, {63'd0, fuse_hit}, {63'd0, fz});
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; op = 2'b00; a = '0; b = '0; rd_addr_i = '0; hold = 1'b0; flush = 1'b0;
    #2;
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_data", {32'd0, out_data}, 64'd0);
    check_eq("rst_rd", {59'd0, out_rd}, 64'd0);
    check_eq("rst_pend", {32'd0, pending_mask}, 64'd0);
    check_eq("rst_fuse", {63'd0, fuse_hit}, 64'd0);
    check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
    step(); step();
    rst = 1'b1;

    // MULH / MUL of 0x80000000 squared
    step(); drive(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 1'b0, 1'b0);
    check_eq("s1_pend0", {32'd0, pending_mask}, 64'h0);
    step(); drive(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 5'd7, 1'b0, 1'b0);
    check_eq("s1_pend1", {32'd0, pending_mask}, 64'h8);
    step(); idle();
    check_eq("s1_early", {63'd0, out_valid}, 64'd0);
    step(); idle();
    expect_ret("s1_mulh", 32'h4000_0000, 5'd3, 1'b0);
    step(); idle();
    expect_ret("s1_mul", 32'h0000_0000, 5'd7, FZ);
    step(); idle();
    check_eq("s1_done", {63'd0, out_valid}, 64'd0);
    check_eq("s1_rd_hold", {59'd0, out_rd}, 64'd7);

    // all-ones operands, three back-to-back ops
    step(); drive(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b0);
    check_eq("s2_pend1", {32'd0, pending_mask}, 64'h2);
    step(); drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, 1'b0);
    step(); idle();
    check_eq("s2_pend3", {32'd0, pending_mask}, 64'h16);
    expect_ret("s2_mulhsu", 32'hFFFF_FFFF, 5'd1, 1'b0);
    step(); idle();
    expect_ret("s2_mulhu", 32'hFFFF_FFFE, 5'd2, 1'b0);
    step(); idle();
    expect_ret("s2_mul", 32'h0000_0001, 5'd4, FZ);
    check_eq("s2_pend5", {32'd0, pending_mask}, 64'h10);
    step(); idle();
    check_eq("s2_pend6", {32'd0, pending_mask}, 64'h0);

    // rd = 0 flows and retires but never shows in the mask
    step(); drive(1'b1, 2'b00, 32'd3, 32'd5, 5'd0, 1'b0, 1'b0);
    step(); idle();
    check_eq("x0_pend", {32'd0, pending_mask}, 64'h0);
    step(); idle();
    step(); idle();
    expect_ret("x0_ret", 32'd15, 5'd0, 1'b0);

    // hold for two cycles after the second accept
    step(); drive(1'b1, 2'b00, 32'd2, 32'd3, 5'd1, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'd2, 5'd2, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'd5, 5'd3, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b1, 1'b0);
    check_eq("h_ready0", {63'd0, in_ready}, 64'd0);
    check_eq("h_valid0", {63'd0, out_valid}, 64'd0);
    check_eq("h_pend0", {32'd0, pending_mask}, 64'hE);
    step(); drive(1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b1, 1'b0);
    check_eq("h_ready1", {63'd0, in_ready}, 64'd0);
    check_eq("h_valid1", {63'd0, out_valid}, 64'd0);
    check_eq("h_pend1", {32'd0, pending_mask}, 64'hE);
    step(); drive(1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b0, 1'b0);
    check_eq("h_ready2", {63'd0, in_ready}, 64'd1);
    expect_ret("h_a", 32'd6, 5'd1, 1'b0);
    step(); idle();
    expect_ret("h_b", 32'd1, 5'd2, 1'b0);
    step(); idle();
    expect_ret("h_c", 32'hFFFF_FFFF, 5'd3, 1'b0);
    step(); idle();
    expect_ret("h_d", 32'hC000_0000, 5'd4, 1'b0);
    step(); idle();
    check_eq("h_done", {63'd0, out_valid}, 64'd0);

    // flush with three in flight and a fourth offered in the flush cycle
    step(); drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd5, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b00, 32'd3, 32'd3, 5'd6, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b00, 32'd4, 32'd4, 5'd7, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b00, 32'd5, 32'd5, 5'd8, 1'b0, 1'b1);
    check_eq("f_pend_pre", {32'd0, pending_mask}, 64'hE0);
    step(); idle();
    check_eq("f_pend_post", {32'd0, pending_mask}, 64'h0);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) vcount++;
      step(); idle();
    end
    check_eq("f_no_retire", 64'(vcount), 64'd0);

    // async reset with two ops in flight
    step(); drive(1'b1, 2'b00, 32'd10, 32'd10, 5'd10, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b11, 32'd11, 32'd11, 5'd11, 1'b0, 1'b0);
    step(); idle();
    check_eq("r_pend_pre", {32'd0, pending_mask}, 64'hC00);
    rst = 1'b0;
    #1;
    check_eq("r_valid", {63'd0, out_valid}, 64'd0);
    check_eq("r_data", {32'd0, out_data}, 64'd0);
    check_eq("r_rd", {59'd0, out_rd}, 64'd0);
    check_eq("r_pend", {32'd0, pending_mask}, 64'd0);
    check_eq("r_fuse", {63'd0, fuse_hit}, 64'd0);
    step();
    rst = 1'b1;
    idle();
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) vcount++;
      step(); idle();
    end
    check_eq("r_no_retire", 64'(vcount), 64'd0);
    drive(1'b1, 2'b00, 32'd6, 32'd7, 5'd9, 1'b0, 1'b0);
    step(); idle();
    step(); idle();
    check_eq("r_early", {63'd0, out_valid}, 64'd0);
    step(); idle();
    expect_ret("r_mul42", 32'd42, 5'd9, 1'b0);

    // MULHU then MUL on the same operands
    step(); drive(1'b1, 2'b11, 32'd7, 32'd9, 5'd5, 1'b0, 1'b0);
    step(); drive(1'b1, 2'b00, 32'd7, 32'd9, 5'd6, 1'b0, 1'b0);
    step(); idle();
    step(); idle();
    expect_ret("z_mulhu", 32'd0, 5'd5, 1'b0);
    step(); idle();
    expect_ret("z_mul", 32'd63, 5'd6, FZ);
    step(); idle();

    // same pair with a flush between them
    step(); drive(1'b1, 2'b11, 32'd7, 32'd9, 5'd5, 1'b0, 1'b0);
    step(); drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    step(); drive(1'b1, 2'b00, 32'd7, 32'd9, 5'd6, 1'b0, 1'b0);
    step(); idle();
    check_eq("zf_gap0", {63'd0, out_valid}, 64'd0);
    step(); idle();
    check_eq("zf_gap1", {63'd0, out_valid}, 64'd0);
    step(); idle();
    expect_ret("zf_mul", 32'd63, 5'd6, 1'b0);
    step(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
